// File: rtl/neo_audio_pkg.sv
// Shared helpers for the Neo-Geo audio path.
// Contents:
//   - I2S slot constants.
//   - clog2, a constant-friendly ceiling log2.
//   - sat_add, a signed add that clamps the result to a w-bit two's complement range.
package neo_audio_pkg;

    localparam logic LRCK_LEFT    = 1'b0;
    localparam logic LRCK_RIGHT   = 1'b1;
    // The word MSB goes out one slot after LRCK changes (I2S delay).
    localparam int   SLOT_MSB_OFS = 1;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) r = i + 1;
        end
        return r;
    endfunction

    // Returns a+b clamped to [-2^(w-1), 2^(w-1)-1], with the clip flag on the side.
    function automatic logic signed [63:0] sat_add(
        input  logic signed [63:0] a,
        input  logic signed [63:0] b,
        input  int                 w,
        output logic               clipped
    );
        logic signed [63:0] s;
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        s       = a + b;
        hi      = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo      = -(64'sd1 <<< (w - 1));
        clipped = 1'b0;
        if (s > hi) begin
            s       = hi;
            clipped = 1'b1;
        end else if (s < lo) begin
            s       = lo;
            clipped = 1'b1;
        end
        return s;
    endfunction

endpackage

// File: rtl/i2s_tx.sv
// I2S transmitter: BCLK divider, slot counter, frame shift registers, LRCK/SDTI.
// Ports:
//   clk, rst_n        system clock, async active-low reset
//   word_l, word_r    mixed words, sampled at each frame load
//   flag_l, flag_r    clip flags travelling with the words
//   mclk              clk/2
//   bick, lrck, sdti  I2S bit clock, word select (0 = left) and data
//   frame_stb         one-cycle pulse at each frame load
//   sat_l, sat_r      one-cycle pulse at load when that word was clipped
module i2s_tx
    import neo_audio_pkg::*;
#(
    parameter int SAMPLE_W   = 16,
    parameter int FRAME_BITS = 32,
    parameter int BCLK_DIV   = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [SAMPLE_W-1:0] word_l,
    input  logic [SAMPLE_W-1:0] word_r,
    input  logic                flag_l,
    input  logic                flag_r,
    output logic                mclk,
    output logic                bick,
    output logic                lrck,
    output logic                sdti,
    output logic                frame_stb,
    output logic                sat_l,
    output logic                sat_r
);

    localparam int SLOTS = 2 * FRAME_BITS;
    localparam int DIV_W = (clog2(BCLK_DIV) > 0) ? clog2(BCLK_DIV) : 1;
    localparam int CNT_W = clog2(SLOTS);

    logic [DIV_W-1:0]    div_cnt;
    logic [CNT_W-1:0]    bit_cnt;
    logic [CNT_W-1:0]    bit_nxt;
    logic [SAMPLE_W-1:0] sh_l;
    logic [SAMPLE_W-1:0] sh_r;
    logic                wrap;
    logic                fall;
    int                  slot;

    always_comb begin
        wrap    = (div_cnt == DIV_W'(BCLK_DIV - 1));
        fall    = wrap & bick;
        bit_nxt = (bit_cnt == CNT_W'(SLOTS - 1)) ? '0 : bit_cnt + CNT_W'(1);
        slot    = int'(bit_nxt);
    end

    // Every serial output is decided from the slot being entered on this fall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mclk      <= 1'b0;
            bick      <= 1'b0;
            lrck      <= 1'b0;
            sdti      <= 1'b0;
            frame_stb <= 1'b0;
            sat_l     <= 1'b0;
            sat_r     <= 1'b0;
            div_cnt   <= '0;
            bit_cnt   <= '0;
            sh_l      <= '0;
            sh_r      <= '0;
        end else begin
            mclk      <= ~mclk;
            div_cnt   <= wrap ? '0 : div_cnt + DIV_W'(1);
            frame_stb <= 1'b0;
            sat_l     <= 1'b0;
            sat_r     <= 1'b0;
            if (wrap) bick <= ~bick;
            if (fall) begin
                bit_cnt <= bit_nxt;
                lrck    <= (slot >= FRAME_BITS) ? LRCK_RIGHT : LRCK_LEFT;
                if (slot == 0) begin
                    sh_l      <= word_l;
                    sh_r      <= word_r;
                    frame_stb <= 1'b1;
                    sat_l     <= flag_l;
                    sat_r     <= flag_r;
                    sdti      <= 1'b0;
                end else if (slot >= SLOT_MSB_OFS && slot < SLOT_MSB_OFS + SAMPLE_W) begin
                    sdti <= sh_l[SAMPLE_W-1];
                    sh_l <= sh_l << 1;
                end else if (slot >= FRAME_BITS + SLOT_MSB_OFS &&
                             slot <  FRAME_BITS + SLOT_MSB_OFS + SAMPLE_W) begin
                    sdti <= sh_r[SAMPLE_W-1];
                    sh_r <= sh_r << 1;
                end else begin
                    sdti <= 1'b0;
                end
            end
        end
    end

endmodule

// File: rtl/neo_i2s_mix.sv
// N-source PCM mixer with per-source L/R routing and saturation, feeding an I2S transmitter.
// Ports:
//   CLK_24M, nRESET      system clock, async active-low reset
//   SMP_IN, SMP_STB      packed signed source samples and per-source load strobes
//   PAN                  bit 2i routes source i left, bit 2i+1 routes it right
//   I2S_MCLK/BICK/LRCK/SDTI  I2S stream
//   FRAME_STB            pulse at each frame load
//   SAT_L, SAT_R         pulse at load when the loaded word was clipped
module neo_i2s_mix
    import neo_audio_pkg::*;
#(
    parameter int N_SRC      = 2,
    parameter int SAMPLE_W   = 16,
    parameter int FRAME_BITS = 32,
    parameter int BCLK_DIV   = 4
) (
    input  logic                      CLK_24M,
    input  logic                      nRESET,
    input  logic [N_SRC*SAMPLE_W-1:0] SMP_IN,
    input  logic [N_SRC-1:0]          SMP_STB,
    input  logic [2*N_SRC-1:0]        PAN,
    output logic                      I2S_MCLK,
    output logic                      I2S_BICK,
    output logic                      I2S_LRCK,
    output logic                      I2S_SDTI,
    output logic                      FRAME_STB,
    output logic                      SAT_L,
    output logic                      SAT_R
);

    localparam int SUM_W = SAMPLE_W + clog2(N_SRC) + 1;

    logic [SAMPLE_W-1:0]     hold [N_SRC];
    logic signed [SUM_W-1:0] sum_l;
    logic signed [SUM_W-1:0] sum_r;
    logic [SAMPLE_W-1:0]     mix_l_d;
    logic [SAMPLE_W-1:0]     mix_r_d;
    logic                    clip_l;
    logic                    clip_r;
    logic [SAMPLE_W-1:0]     mix_l;
    logic [SAMPLE_W-1:0]     mix_r;
    logic                    mix_sat_l;
    logic                    mix_sat_r;

    always_ff @(posedge CLK_24M or negedge nRESET) begin
        if (!nRESET) begin
            for (int i = 0; i < N_SRC; i++) hold[i] <= '0;
        end else begin
            for (int i = 0; i < N_SRC; i++) begin
                if (SMP_STB[i]) hold[i] <= SMP_IN[i*SAMPLE_W +: SAMPLE_W];
            end
        end
    end

    always_comb begin
        sum_l  = '0;
        sum_r  = '0;
        clip_l = 1'b0;
        clip_r = 1'b0;
        for (int i = 0; i < N_SRC; i++) begin
            if (PAN[2*i])   sum_l = sum_l + SUM_W'(signed'(hold[i]));
            if (PAN[2*i+1]) sum_r = sum_r + SUM_W'(signed'(hold[i]));
        end
        mix_l_d = SAMPLE_W'(sat_add(64'(sum_l), 64'sd0, SAMPLE_W, clip_l));
        mix_r_d = SAMPLE_W'(sat_add(64'(sum_r), 64'sd0, SAMPLE_W, clip_r));
    end

    always_ff @(posedge CLK_24M or negedge nRESET) begin
        if (!nRESET) begin
            mix_l     <= '0;
            mix_r     <= '0;
            mix_sat_l <= 1'b0;
            mix_sat_r <= 1'b0;
        end else begin
            mix_l     <= mix_l_d;
            mix_r     <= mix_r_d;
            mix_sat_l <= clip_l;
            mix_sat_r <= clip_r;
        end
    end

    i2s_tx #(
        .SAMPLE_W   (SAMPLE_W),
        .FRAME_BITS (FRAME_BITS),
        .BCLK_DIV   (BCLK_DIV)
    ) u_tx (
        .clk       (CLK_24M),
        .rst_n     (nRESET),
        .word_l    (mix_l),
        .word_r    (mix_r),
        .flag_l    (mix_sat_l),
        .flag_r    (mix_sat_r),
        .mclk      (I2S_MCLK),
        .bick      (I2S_BICK),
        .lrck      (I2S_LRCK),
        .sdti      (I2S_SDTI),
        .frame_stb (FRAME_STB),
        .sat_l     (SAT_L),
        .sat_r     (SAT_R)
    );

endmodule
